// File: rtl/cfu_simd_mac_if.sv
// cfu_simd_mac_if: CPU-to-CFU command/response handshake bundle
interface cfu_simd_mac_if;
    logic        cmd_valid;
    logic        cmd_ready;
    logic [9:0]  cmd_payload_function_id;
    logic [31:0] cmd_payload_inputs_0;
    logic [31:0] cmd_payload_inputs_1;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [31:0] rsp_payload_outputs_0;
    modport master (
        output cmd_valid, cmd_payload_function_id, cmd_payload_inputs_0, cmd_payload_inputs_1, rsp_ready,
        input  cmd_ready, rsp_valid, rsp_payload_outputs_0
    );
    modport slave (
        input  cmd_valid, cmd_payload_function_id, cmd_payload_inputs_0, cmd_payload_inputs_1, rsp_ready,
        output cmd_ready, rsp_valid, rsp_payload_outputs_0
    );
endinterface

// File: rtl/cfu_simd_mac.sv
// cfu_simd_mac: input-stationary multi-channel int8 SIMD multiply-accumulate custom function unit
module cfu_simd_mac #(
    parameter int NUM_CH = 2,
    parameter int DEPTH  = 256,
    parameter int ACC_W  = 32
) (
    input logic clk,
    input logic reset,
    cfu_simd_mac_if.slave bus
);
    localparam int AW = $clog2(DEPTH);
    localparam int SW = ACC_W > 20 ? ACC_W : 20;
    logic [2:0]    f3;
    logic [6:0]    f7;
    logic [31:0]   a, b, mac_rsp, rsp_d;
    logic [31:0]   rd_buf [8];
    logic [31:0]   rd_acc [8];
    logic [AW-1:0] ptr, ptr_nx, ptr_odd, b_addr;
    logic [8:0]    ofs;
    logic accept, is_clr, is_mac, is_ofs, is_sptr, is_wr, wr_ok, is_rbuf, is_racc;
    function automatic logic [31:0] to32(input logic [ACC_W-1:0] v);
        return 32'($signed(v));
    endfunction
    // offset-corrected input fits 10 bits; the product always fits 17 bits signed
    function automatic logic signed [16:0] lane(input logic [7:0] x, input logic [7:0] w, input logic [8:0] o);
        logic [9:0] xi;
        xi = {{2{x[7]}}, x} + {o[8], o};
        return {{7{xi[9]}}, xi} * {{9{w[7]}}, w};
    endfunction
    assign f3 = bus.cmd_payload_function_id[2:0];
    assign f7 = bus.cmd_payload_function_id[9:3];
    assign a = bus.cmd_payload_inputs_0;
    assign b = bus.cmd_payload_inputs_1;
    assign bus.cmd_ready = ~bus.rsp_valid;
    assign accept = bus.cmd_valid && !bus.rsp_valid && !reset;
    assign is_clr = f3 == 3'd0 && f7 == 7'd0;
    assign is_mac = f3 == 3'd0 && f7 == 7'd1;
    assign is_ofs = f3 == 3'd0 && f7 == 7'd2;
    assign is_sptr = f3 == 3'd1 && f7 == 7'd0;
    assign is_rbuf = f3 == 3'd1 && f7 == 7'd2;
    assign is_racc = f3 == 3'd1 && f7 == 7'd3;
    assign is_wr = f3 == 3'd2;
    assign wr_ok = is_wr && f7 < 7'(NUM_CH);
    assign ptr_nx = ptr + AW'(2);
    assign ptr_odd = {ptr[AW-1:1], 1'b1};
    assign b_addr = b[AW-1:0];
    // absent channels read as all-ones so out-of-range indices need no separate compare
    for (genvar g = 0; g < 8; g++) begin : ch
        if (g < NUM_CH) begin : live
            logic [31:0]    mem [DEPTH];
            logic [63:0]    dat, wt;
            logic [SW-1:0]  sum;
            logic [ACC_W-1:0] acc, acc_nx;
            always_ff @(posedge clk)
                if (accept && wr_ok && f7 == 7'(g)) begin
                    mem[ptr] <= a;
                    mem[ptr_odd] <= b;
                end
            assign dat = {mem[ptr_odd], mem[ptr]};
            assign wt = {b, a};
            always_comb begin
                sum = '0;
                for (int l = 0; l < 8; l++)
                    sum = sum + SW'(lane(dat[8*l +: 8], wt[8*l +: 8], ofs));
            end
            assign acc_nx = acc + sum[ACC_W-1:0];
            always_ff @(posedge clk)
                if (reset) acc <= '0;
                else if (accept && is_clr) acc <= '0;
                else if (accept && is_mac) acc <= acc_nx;
            assign rd_buf[g] = mem[b_addr];
            assign rd_acc[g] = to32(acc);
            if (g == 0) begin : first
                assign mac_rsp = to32(acc_nx);
            end
        end else begin : dead
            assign rd_buf[g] = '1;
            assign rd_acc[g] = '1;
        end
    end
    assign rsp_d = (is_clr || is_sptr) ? 32'd0 :
                   is_mac  ? mac_rsp :
                   is_ofs  ? 32'($signed(ofs)) :
                   is_wr   ? (wr_ok ? 32'(ptr_nx) : 32'hFFFF_FFFF) :
                   is_rbuf ? rd_buf[a[2:0]] :
                   is_racc ? rd_acc[a[2:0]] : 32'd0;
    always_ff @(posedge clk) begin
        if (reset) begin
            bus.rsp_valid <= 1'b0;
            bus.rsp_payload_outputs_0 <= '0;
            ptr <= '0;
            ofs <= 9'd128;
        end else if (accept) begin
            bus.rsp_valid <= 1'b1;
            bus.rsp_payload_outputs_0 <= rsp_d;
            ptr <= is_clr ? '0 : (is_mac || wr_ok) ? ptr_nx : is_sptr ? {a[AW-1:1], 1'b0} : ptr;
            ofs <= is_ofs ? a[8:0] : ofs;
        end else if (bus.rsp_ready) begin
            bus.rsp_valid <= 1'b0;
        end
    end
endmodule

// File: tb/tb_cfu_simd_mac.sv
// tb_cfu_simd_mac: directed scoreboard bench for cfu_simd_mac
module tb_cfu_simd_mac;
    logic clk = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;
    cfu_simd_mac_if bus ();
    cfu_simd_mac dut (.clk(clk), .reset(reset), .bus(bus));
    typedef struct { string name; logic [31:0] exp; } exp_t;
    exp_t sb[$];
    int checks = 0;
    int errors = 0;
    function automatic void check(string name, logic [31:0] got, logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h want %h", name, got, exp);
        end
    endfunction
    function automatic logic [9:0] fid(int f7, int f3);
        return {7'(f7), 3'(f3)};
    endfunction
    always @(negedge clk)
        if (bus.rsp_valid && bus.rsp_ready) begin
            exp_t e;
            if (sb.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_rsp: got %h want no response", bus.rsp_payload_outputs_0);
            end else begin
                e = sb.pop_front();
                check(e.name, bus.rsp_payload_outputs_0, e.exp);
            end
        end
    task automatic send(string name, logic [9:0] f, logic [31:0] a, logic [31:0] b, logic [31:0] exp);
        int n = 0;
        sb.push_back('{name, exp});
        bus.cmd_payload_function_id = f;
        bus.cmd_payload_inputs_0 = a;
        bus.cmd_payload_inputs_1 = b;
        bus.cmd_valid = 1'b1;
        do begin
            @(negedge clk);
            n++;
        end while (!bus.cmd_ready && n < 50);
        if (!bus.cmd_ready) begin
            checks++;
            errors++;
            $display("FAIL %s_accept: cmd_ready got 0 want 1", name);
        end
        @(posedge clk);
        #1 bus.cmd_valid = 1'b0;
    endtask
    task automatic drain();
        @(posedge clk);
        #1;
    endtask
    initial begin
        #200000;
        $display("FAIL watchdog: simulation got no end want finish");
        $fatal(1);
    end
    initial begin
        int n;
        bus.cmd_valid = 1'b1;
        bus.cmd_payload_function_id = fid(2, 0);
        bus.cmd_payload_inputs_0 = 32'd9;
        bus.cmd_payload_inputs_1 = 32'd0;
        bus.rsp_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check("rst_rsp_valid", 32'(bus.rsp_valid), 0);
        check("rst_payload", bus.rsp_payload_outputs_0, 0);
        check("rst_cmd_ready", 32'(bus.cmd_ready), 1);
        reset = 1'b0;
        bus.cmd_valid = 1'b0;
        drain();
        check("post_rst_idle", 32'(bus.rsp_valid), 0);
        send("clear", fid(0, 0), 0, 0, 0);
        send("wr0_zero", fid(0, 2), 0, 0, 2);
        send("ptr0_a", fid(0, 1), 0, 0, 0);
        send("wr1_zero", fid(1, 2), 0, 0, 2);
        send("ptr0_b", fid(0, 1), 0, 0, 0);
        send("mac_ofs128", fid(1, 0), 32'h01010101, 32'h01010101, 32'd1024);
        send("racc1_a", fid(3, 1), 1, 0, 32'd1024);
        send("ptr0_c", fid(0, 1), 0, 0, 0);
        send("wr1_7f", fid(1, 2), 32'h7F7F7F7F, 32'h7F7F7F7F, 2);
        send("ptr0_d", fid(0, 1), 0, 0, 0);
        send("mac_neg", fid(1, 0), 32'hFFFFFFFF, 32'hFFFFFFFF, 0);
        send("racc1_b", fid(3, 1), 1, 0, 32'hFFFFFC08);
        send("ofs_to0", fid(2, 0), 0, 0, 32'd128);
        send("ptr2_a", fid(0, 1), 2, 0, 0);
        send("wr0_02", fid(0, 2), 32'h02020202, 32'h02020202, 4);
        send("ptr2_b", fid(0, 1), 2, 0, 0);
        send("wr1_zero2", fid(1, 2), 0, 0, 4);
        send("ptr2_c", fid(0, 1), 2, 0, 0);
        send("mac_ofs0", fid(1, 0), 32'h03030303, 32'h03030303, 32'd48);
        send("rbuf0_2", fid(2, 1), 0, 2, 32'h02020202);
        send("rbuf0_1", fid(2, 1), 0, 1, 0);
        send("rbuf1_0", fid(2, 1), 1, 0, 32'h7F7F7F7F);
        send("ptr2_d", fid(0, 1), 2, 0, 0);
        drain();
        bus.rsp_ready = 1'b0;
        send("mac_stall", fid(1, 0), 32'h03030303, 32'h03030303, 32'd96);
        bus.cmd_valid = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check("stall_cmd_ready", 32'(bus.cmd_ready), 0);
            check("stall_rsp_valid", 32'(bus.rsp_valid), 1);
        end
        @(posedge clk);
        #1;
        bus.cmd_valid = 1'b0;
        bus.rsp_ready = 1'b1;
        send("racc0_stall", fid(3, 1), 0, 0, 32'd96);
        send("racc1_c", fid(3, 1), 1, 0, 32'hFFFFFC08);
        send("ptr_top", fid(0, 1), 254, 0, 0);
        send("wr0_wrap", fid(0, 2), 32'h11111111, 32'hCAFEBABE, 0);
        send("rbuf0_255", fid(2, 1), 0, 255, 32'hCAFEBABE);
        send("rbuf0_mod", fid(2, 1), 0, 32'h1FE, 32'h11111111);
        send("ptr_odd", fid(0, 1), 5, 0, 0);
        send("wr0_at4", fid(0, 2), 1, 2, 6);
        send("rbuf0_4", fid(2, 1), 0, 4, 1);
        send("wr7_bad", fid(7, 2), 32'hDEADBEEF, 32'hDEADBEEF, 32'hFFFFFFFF);
        send("wr1_after_bad", fid(1, 2), 32'h55, 32'h55, 8);
        send("rbuf7_bad", fid(2, 1), 7, 0, 32'hFFFFFFFF);
        send("racc2_bad", fid(3, 1), 2, 0, 32'hFFFFFFFF);
        send("rbuf1_kept", fid(2, 1), 1, 0, 32'h7F7F7F7F);
        send("undef_f3_3", fid(0, 3), 5, 5, 0);
        send("undef_f7_9", fid(9, 0), 5, 5, 0);
        send("undef_11", fid(1, 1), 5, 5, 0);
        send("wr0_after_undef", fid(0, 2), 0, 0, 10);
        send("racc0_after", fid(3, 1), 0, 0, 32'd96);
        send("ofs_neg", fid(2, 0), 32'h1FF, 0, 0);
        send("ofs_back", fid(2, 0), 0, 0, 32'hFFFFFFFF);
        send("clear2", fid(0, 0), 0, 0, 0);
        send("racc1_clr", fid(3, 1), 1, 0, 0);
        send("wr0_after_clr", fid(0, 2), 0, 0, 2);
        drain();
        bus.rsp_ready = 1'b0;
        bus.cmd_payload_function_id = fid(2, 0);
        bus.cmd_payload_inputs_0 = 32'd5;
        bus.cmd_valid = 1'b1;
        @(posedge clk);
        #1 bus.cmd_valid = 1'b0;
        @(negedge clk);
        check("pend_rsp_valid", 32'(bus.rsp_valid), 1);
        reset = 1'b1;
        bus.cmd_payload_inputs_0 = 32'd7;
        bus.cmd_valid = 1'b1;
        @(posedge clk);
        #1;
        check("rst_drop_valid", 32'(bus.rsp_valid), 0);
        check("rst_drop_payload", bus.rsp_payload_outputs_0, 0);
        reset = 1'b0;
        bus.cmd_valid = 1'b0;
        bus.rsp_ready = 1'b1;
        drain();
        check("post_rst2_idle", 32'(bus.rsp_valid), 0);
        send("ofs_after_rst", fid(2, 0), 0, 0, 32'd128);
        send("racc0_rst", fid(3, 1), 0, 0, 0);
        send("wr0_rst", fid(0, 2), 0, 0, 2);
        n = 0;
        while (sb.size() != 0 && n < 100) begin
            @(posedge clk);
            n++;
        end
        check("sb_empty", 32'(sb.size()), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
